ras_link_pool: RTL and testbench

//  Multi-channel return-address-stack address generator: N_CH independent stacks share one pool of

---
 rtl/ras_link_pool.sv | 213 +++++++++++++++++++++
 tb/tb_ras_link_pool.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_link_pool.sv
// ras_link_pool: address generator for a multi-channel return-address stack.
// N_CH independent stacks share DEPTH entries carved into blocks of SCRATCHPAD_DEPTH
// entries. Each channel links its blocks backwards through a shared prev_link table.
// Blocks come from a LIFO free list. They return to it on a POP that crosses a block
// boundary, or through a multi-cycle CLOSE walk down the channel's chain.
//
// Ports
//   clk, reset    clock; asynchronous active-high reset
//   op_valid/op_ready/op_ch/op_code
//                 operation handshake. Codes: 0 NOP, 1 OPEN, 2 PUSH, 3 POP, 4 CLOSE.
//                 Codes 5-7 are illegal.
//   resp_valid/resp_ch/resp_addr/resp_err
//                 one-cycle response carrying the entry address {block, offset}
//   ch_active     channel owns a chain
//   ch_empty      channel is active and holds no entries
//   free_blocks   number of blocks on the free list
module ras_link_pool #(
  parameter int unsigned DEPTH            = 1024,
  parameter int unsigned SCRATCHPAD_DEPTH = 16,
  parameter int unsigned N_CH             = 4,
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned AW  = $clog2(DEPTH),
  localparam int unsigned NB  = DEPTH / SCRATCHPAD_DEPTH,
  localparam int unsigned FW  = $clog2(NB + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [CHW-1:0]  op_ch,
  input  logic [2:0]      op_code,
  output logic            resp_valid,
  output logic [CHW-1:0]  resp_ch,
  output logic [AW-1:0]   resp_addr,
  output logic            resp_err,
  output logic [N_CH-1:0] ch_active,
  output logic [N_CH-1:0] ch_empty,
  output logic [FW-1:0]   free_blocks
);

  localparam int unsigned OW  = $clog2(SCRATCHPAD_DEPTH);
  localparam int unsigned BW  = AW - OW;
  localparam int unsigned DW  = $clog2(DEPTH + 1);
  localparam int unsigned CHS = 1 << CHW;

  localparam logic [OW-1:0]  OFF_MAX  = OW'(SCRATCHPAD_DEPTH - 1);
  localparam logic [FW-1:0]  NB_F     = FW'(NB);
  // Channel codes that address a real channel (matters when N_CH is not a power of 2)
  localparam logic [CHS-1:0] CH_VALID = CHS'((64'(1) << N_CH) - 64'(1));

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_OPEN  = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_CLOSE = 3'd4;

  typedef enum logic [0:0] {S_IDLE, S_WALK} state_t;

  state_t        state;
  logic [BW-1:0] fl        [NB];   // free-list stack; top is fl[NB - free_blocks]
  logic [BW-1:0] prev_link [NB];
  logic [AW-1:0] ptr       [N_CH];
  logic [DW-1:0] depth     [N_CH];
  logic [FW-1:0] blk_cnt   [N_CH];
  logic [CHW-1:0] walk_ch;
  logic [BW-1:0]  walk_blk;
  logic [FW-1:0]  walk_left;

  logic [AW-1:0] cur_ptr;
  logic [BW-1:0] cur_blk;
  logic [OW-1:0] cur_off;
  logic [DW-1:0] cur_depth;
  logic [FW-1:0] cur_cnt;
  logic          cur_active;
  logic [BW-1:0] pop_idx;
  logic [BW-1:0] push_idx;
  logic [BW-1:0] fl_top;
  logic          op_err;

  // Decode the addressed channel and classify the request
  always_comb begin
    cur_ptr    = ptr[op_ch];
    cur_blk    = cur_ptr[AW-1:OW];
    cur_off    = cur_ptr[OW-1:0];
    cur_depth  = depth[op_ch];
    cur_cnt    = blk_cnt[op_ch];
    cur_active = ch_active[op_ch];
    pop_idx    = BW'(NB_F - free_blocks);
    push_idx   = BW'(NB_F - free_blocks - FW'(1));
    fl_top     = fl[pop_idx];
    op_err     = 1'b0;
    case (op_code)
      OP_NOP:   op_err = 1'b0;
      OP_OPEN:  op_err = !CH_VALID[op_ch] || cur_active || (free_blocks == '0);
      OP_PUSH:  op_err = !CH_VALID[op_ch] || !cur_active ||
                         ((cur_off == OFF_MAX) && (free_blocks == '0));
      OP_POP:   op_err = !CH_VALID[op_ch] || !cur_active || (cur_depth == '0);
      OP_CLOSE: op_err = !CH_VALID[op_ch] || !cur_active;
      default:  op_err = 1'b1;
    endcase
  end

  // Operation execution, free-list management and the CLOSE walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_ready    <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_addr   <= '0;
      resp_ch     <= '0;
      ch_active   <= '0;
      ch_empty    <= '0;
      free_blocks <= NB_F;
      walk_ch     <= '0;
      walk_blk    <= '0;
      walk_left   <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        fl[i]        <= BW'(i);
        prev_link[i] <= '0;
      end
      for (int unsigned c = 0; c < N_CH; c++) begin
        ptr[c]     <= '0;
        depth[c]   <= '0;
        blk_cnt[c] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_addr  <= '0;
      case (state)
        S_IDLE: begin
          if (op_valid && (op_code != OP_NOP)) begin
            resp_ch <= op_ch;
            if (op_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              case (op_code)
                OP_OPEN: begin
                  free_blocks      <= free_blocks - FW'(1);
                  ptr[op_ch]       <= {fl_top, OW'(0)};
                  depth[op_ch]     <= '0;
                  blk_cnt[op_ch]   <= FW'(1);
                  ch_active[op_ch] <= 1'b1;
                  ch_empty[op_ch]  <= 1'b1;
                  resp_valid       <= 1'b1;
                  resp_addr        <= {fl_top, OW'(0)};
                end
                OP_PUSH: begin
                  resp_valid      <= 1'b1;
                  resp_addr       <= cur_ptr;
                  depth[op_ch]    <= cur_depth + DW'(1);
                  ch_empty[op_ch] <= 1'b0;
                  // Writing the last slot of a block chains in a fresh one
                  if (cur_off == OFF_MAX) begin
                    free_blocks       <= free_blocks - FW'(1);
                    prev_link[fl_top] <= cur_blk;
                    ptr[op_ch]        <= {fl_top, OW'(0)};
                    blk_cnt[op_ch]    <= cur_cnt + FW'(1);
                  end else begin
                    ptr[op_ch] <= cur_ptr + AW'(1);
                  end
                end
                OP_POP: begin
                  resp_valid      <= 1'b1;
                  depth[op_ch]    <= cur_depth - DW'(1);
                  ch_empty[op_ch] <= (cur_depth == DW'(1));
                  // Leaving a block through offset 0 returns it to the free list
                  if (cur_off == '0) begin
                    fl[push_idx]   <= cur_blk;
                    free_blocks    <= free_blocks + FW'(1);
                    ptr[op_ch]     <= {prev_link[cur_blk], OFF_MAX};
                    resp_addr      <= {prev_link[cur_blk], OFF_MAX};
                    blk_cnt[op_ch] <= cur_cnt - FW'(1);
                  end else begin
                    ptr[op_ch] <= cur_ptr - AW'(1);
                    resp_addr  <= cur_ptr - AW'(1);
                  end
                end
                OP_CLOSE: begin
                  state     <= S_WALK;
                  op_ready  <= 1'b0;
                  walk_ch   <= op_ch;
                  walk_blk  <= cur_blk;
                  walk_left <= cur_cnt;
                end
                default: ;
              endcase
            end
          end
        end
        S_WALK: begin
          // Free one block per cycle, newest first, following the back links
          fl[push_idx] <= walk_blk;
          free_blocks  <= free_blocks + FW'(1);
          walk_blk     <= prev_link[walk_blk];
          walk_left    <= walk_left - FW'(1);
          if (walk_left == FW'(1)) begin
            state              <= S_IDLE;
            op_ready           <= 1'b1;
            ch_active[walk_ch] <= 1'b0;
            ch_empty[walk_ch]  <= 1'b0;
            resp_valid         <= 1'b1;
            resp_ch            <= walk_ch;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ras_link_pool.sv
// Testbench for ras_link_pool: a scoreboard of expected responses, filled by the stimulus
// tasks from a queue-based model of the block pool and drained by a response monitor.
module tb_ras_link_pool;

  localparam int DEPTH = 64;
  localparam int SD    = 16;
  localparam int N_CH  = 2;
  localparam int NB    = DEPTH / SD;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [0:0] op_ch;
  logic [2:0] op_code;
  logic       resp_valid;
  logic [0:0] resp_ch;
  logic [5:0] resp_addr;
  logic       resp_err;
  logic [1:0] ch_active;
  logic [1:0] ch_empty;
  logic [2:0] free_blocks;

  ras_link_pool #(.DEPTH(DEPTH), .SCRATCHPAD_DEPTH(SD), .N_CH(N_CH)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_ch(op_ch), .op_code(op_code),
    .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_addr(resp_addr), .resp_err(resp_err),
    .ch_active(ch_active), .ch_empty(ch_empty), .free_blocks(free_blocks)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int addr;
    bit err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: free list as a LIFO queue, each channel as a list of owned blocks
  int free_q[$];
  bit m_act  [N_CH];
  int m_depth[N_CH];
  int m_blk  [N_CH][NB];
  int m_nblk [N_CH];

  function automatic void check(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    free_q.delete();
    for (int i = NB - 1; i >= 0; i--) free_q.push_back(i);
    for (int c = 0; c < N_CH; c++) begin
      m_act[c] = 1'b0;
      m_depth[c] = 0;
      m_nblk[c] = 0;
    end
  endfunction

  function automatic void model_op(input int ch, input int code, output bit has, output exp_t e);
    int d;
    has = (code != 0);
    e.ch = ch;
    e.addr = 0;
    e.err = 1'b0;
    case (code)
      0: ;
      1: begin
        if (m_act[ch] || free_q.size() == 0) e.err = 1'b1;
        else begin
          m_blk[ch][0] = free_q.pop_back();
          m_nblk[ch] = 1;
          m_depth[ch] = 0;
          m_act[ch] = 1'b1;
          e.addr = m_blk[ch][0] * SD;
        end
      end
      2: begin
        d = m_depth[ch];
        if (!m_act[ch]) e.err = 1'b1;
        else if ((d % SD) == SD - 1 && free_q.size() == 0) e.err = 1'b1;
        else begin
          e.addr = m_blk[ch][d / SD] * SD + d % SD;
          if ((d % SD) == SD - 1) begin
            m_blk[ch][m_nblk[ch]] = free_q.pop_back();
            m_nblk[ch]++;
          end
          m_depth[ch] = d + 1;
        end
      end
      3: begin
        if (!m_act[ch] || m_depth[ch] == 0) e.err = 1'b1;
        else begin
          d = m_depth[ch] - 1;
          m_depth[ch] = d;
          e.addr = m_blk[ch][d / SD] * SD + d % SD;
          while (m_nblk[ch] > d / SD + 1) begin
            m_nblk[ch]--;
            free_q.push_back(m_blk[ch][m_nblk[ch]]);
          end
        end
      end
      4: begin
        if (!m_act[ch]) e.err = 1'b1;
        else begin
          while (m_nblk[ch] > 0) begin
            m_nblk[ch]--;
            free_q.push_back(m_blk[ch][m_nblk[ch]]);
          end
          m_act[ch] = 1'b0;
          m_depth[ch] = 0;
        end
      end
      default: e.err = 1'b1;
    endcase
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got ch %0d addr %0d err %0d, expected no response",
                 resp_ch, resp_addr, resp_err);
      end else begin
        mon_e = sb.pop_front();
        check("resp_ch", 32'(resp_ch), mon_e.ch);
        check("resp_addr", 32'(resp_addr), mon_e.addr);
        check("resp_err", 32'(resp_err), int'(mon_e.err));
      end
    end
  end

  function automatic int act_vec();
    int v = 0;
    for (int c = 0; c < N_CH; c++) if (m_act[c]) v |= (1 << c);
    return v;
  endfunction

  function automatic int empty_vec();
    int v = 0;
    for (int c = 0; c < N_CH; c++) if (m_act[c] && m_depth[c] == 0) v |= (1 << c);
    return v;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance
  task automatic drive(input int ch, input int code);
    bit   has;
    exp_t e;
    int   n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (op_ready !== 1'b1) check("op_ready_timeout", 32'(op_ready), 1);
    model_op(ch, code, has, e);
    if (has) sb.push_back(e);
    op_valid = 1'b1;
    op_ch    = 1'(ch);
    op_code  = 3'(code);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'd0;
  endtask

  task automatic post_check();
    check("op_ready", 32'(op_ready), 1);
    check("free_blocks", 32'(free_blocks), free_q.size());
    check("ch_active", 32'(ch_active), act_vec());
    check("ch_empty", 32'(ch_empty), empty_vec());
  endtask

  task automatic run_op(input int ch, input int code);
    bit closing;
    int nb;
    int n = 0;
    closing = (code == 4) && m_act[ch];
    nb = m_nblk[ch];
    drive(ch, code);
    if (closing) begin
      while (op_ready !== 1'b1 && n < 4 * NB) begin
        n++;
        @(negedge clk);
      end
      check("close_busy_cycles", n, nb);
    end
    post_check();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_err(input string name, input int ch, input int code);
    run_op(ch, code);
    check(name, 32'(resp_err), 1);
    check({name, "_addr"}, 32'(resp_addr), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    op_valid = 1'b0;
    op_ch = 1'b0;
    op_code = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle quiet period
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_resp_valid", 32'(resp_valid), 0);
    end
    post_check();

    // Fill ch0 across one block boundary and step back
    run_op(0, 1);
    for (int i = 0; i < 16; i++) run_op(0, 2);
    run_op(0, 3);
    check("ch0_not_empty", 32'(ch_empty[0]), 0);

    // ch1 reuses the block just freed; ch0 continues where it was
    run_op(1, 1);
    check("ch1_open_addr", 32'(resp_addr), 16);
    run_op(1, 2);
    run_op(0, 2);

    // Exhaust the pool, then hit a block boundary with nothing free
    for (int i = 0; i < 200 && free_q.size() > 0; i++) run_op($urandom_range(0, 1), 2);
    for (int i = 0; i < SD && (m_depth[0] % SD) != SD - 1; i++) run_op(0, 2);
    expect_err("full_push_err", 0, 2);

    // Illegal-request corner cases
    run_op(1, 4);
    expect_err("close_inactive_err", 1, 4);
    run_op(1, 1);
    expect_err("pop_empty_err", 1, 3);
    run_op(1, 4);
    expect_err("push_inactive_err", 1, 2);
    expect_err("open_active_err", 0, 1);
    expect_err("illegal_op6_err", 0, 6);
    expect_err("illegal_op5_err", 1, 5);

    // CLOSE on a three-block chain
    apply_reset();
    run_op(0, 1);
    for (int i = 0; i < 40; i++) run_op(0, 2);
    check("three_blocks_free", 32'(free_blocks), 1);
    run_op(0, 4);
    check("close_free_all", 32'(free_blocks), 4);

    // Reset in the middle of a CLOSE walk
    run_op(0, 1);
    for (int i = 0; i < 40; i++) run_op(0, 2);
    drive(0, 4);
    check("walk_op_ready_low", 32'(op_ready), 0);
    #1 reset = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("rst_walk_free", 32'(free_blocks), 4);
    check("rst_walk_ready", 32'(op_ready), 1);
    check("rst_walk_active", 32'(ch_active), 0);
    check("rst_walk_resp", 32'(resp_valid), 0);
    reset = 1'b0;
    @(negedge clk);
    run_op(1, 1);
    check("post_rst_open_addr", 32'(resp_addr), 0);

    // Randomized mix of operations
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      int code;
      r = $urandom_range(0, 99);
      if (r < 45) code = 2;
      else if (r < 75) code = 3;
      else if (r < 85) code = 1;
      else if (r < 92) code = 4;
      else if (r < 95) code = 0;
      else code = $urandom_range(5, 7);
      run_op($urandom_range(0, 1), code);
    end

    repeat (5) @(negedge clk);
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
